// File: rtl/conv_layer_sched.sv
// Sequences a three-layer CONV run (L0 k0/k1, L1 k0/k1, L2) across the engines, steers the
// shared result-memory select, and aborts a step that overruns its cycle budget.
module conv_layer_sched #(
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned CW      = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    output logic          l0_start,
    output logic          l1_start,
    output logic          l2_start,
    input  logic          l0_done,
    input  logic          l1_done,
    input  logic          l2_done,
    output logic          ksel,
    input  logic          eng_wr,
    input  logic          l2_src,
    output logic [2:0]    csel,
    output logic [2:0]    step,
    output logic          err
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StL0K0 = 3'd1,
        StL0K1 = 3'd2,
        StL1K0 = 3'd3,
        StL1K1 = 3'd4,
        StL2   = 3'd5,
        StFin  = 3'd6
    } state_e;

    localparam logic [CW-1:0] TimeoutCnt = CW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          first_q, first_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          done_hit, done_ok, timeout, in_step, entry;

    function automatic logic is_step(state_e s);
        return (s == StL0K0) || (s == StL0K1) || (s == StL1K0) || (s == StL1K1) || (s == StL2);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        in_step  = is_step(state_q);
        done_hit = 1'b0;
        unique case (state_q)
            StL0K0, StL0K1: done_hit = l0_done;
            StL1K0, StL1K1: done_hit = l1_done;
            StL2:           done_hit = l2_done;
            default:        done_hit = 1'b0;
        endcase
        // The start cycle's own done is treated as stale from the previous step.
        done_ok = done_hit && !first_q;
        timeout = in_step && (cnt_q >= TimeoutCnt);

        case (state_q)
            StIdle: begin
                if (ready) begin
                    state_d = StL0K0;
                    err_d   = 1'b0;
                end
            end
            StL0K0, StL0K1, StL1K0, StL1K1, StL2: begin
                if (done_ok) begin
                    unique case (state_q)
                        StL0K0:  state_d = StL0K1;
                        StL0K1:  state_d = StL1K0;
                        StL1K0:  state_d = StL1K1;
                        StL1K1:  state_d = StL2;
                        default: state_d = StFin;
                    endcase
                end else if (timeout) begin
                    state_d = StFin;
                    err_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        entry   = is_step(state_d) && (state_d != state_q);
        first_d = entry;
        busy_d  = is_step(state_d);
        if (entry) begin
            cnt_d = '0;
        end else if (in_step && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        l0_start = first_q && ((state_q == StL0K0) || (state_q == StL0K1));
        l1_start = first_q && ((state_q == StL1K0) || (state_q == StL1K1));
        l2_start = first_q && (state_q == StL2);
        ksel     = (state_q == StL0K1) || (state_q == StL1K1);
        step     = state_q;
        busy     = busy_q;
        err      = err_q;
        csel     = 3'b000;
        unique case (state_q)
            StL0K0:  csel = 3'b001;
            StL0K1:  csel = 3'b010;
            StL1K0:  csel = eng_wr ? 3'b011 : 3'b001;
            StL1K1:  csel = eng_wr ? 3'b100 : 3'b010;
            StL2:    csel = eng_wr ? 3'b101 : (l2_src ? 3'b100 : 3'b011);
            default: csel = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: normal run, csel steering, timeout, spurious pulses,
// async reset and done-at-timeout priority.
module tb_conv_layer_sched;

    logic       clk = 1'b0;
    logic       reset, ready, l0_done, l1_done, l2_done, eng_wr, l2_src;
    logic       busy, l0_start, l1_start, l2_start, ksel, err;
    logic [2:0] csel, step;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    conv_layer_sched #(.TIMEOUT(20), .CW(17)) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .l0_start(l0_start), .l1_start(l1_start), .l2_start(l2_start),
        .l0_done(l0_done), .l1_done(l1_done), .l2_done(l2_done),
        .ksel(ksel), .eng_wr(eng_wr), .l2_src(l2_src),
        .csel(csel), .step(step), .err(err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle done for step index s (0..4 = L0K0..L2).
    task automatic pulse_done(input int s);
        l0_done = (s == 0 || s == 1);
        l1_done = (s == 2 || s == 3);
        l2_done = (s == 4);
        tick();
        l0_done = 1'b0;
        l1_done = 1'b0;
        l2_done = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; ready = 1'b0; eng_wr = 1'b0; l2_src = 1'b0;
        l0_done = 1'b0; l1_done = 1'b0; l2_done = 1'b0;
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++;
        if ({l2_start, l1_start, l0_start} !== 3'b000) begin
            bad++; $display("FAIL reset_starts got=%b exp=000", {l2_start, l1_start, l0_start});
        end
        total++; if (ksel !== 1'b0) begin bad++; $display("FAIL reset_ksel got=%b exp=0", ksel); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (csel !== 3'd0) begin bad++; $display("FAIL reset_csel got=%b exp=000", csel); end
        total++; if (step !== 3'd0) begin bad++; $display("FAIL reset_step got=%0d exp=0", step); end
        tick();
        reset = 1'b1;
        tick(); tick();
        total++; if (step !== 3'd0) begin bad++; $display("FAIL idle_step got=%0d exp=0", step); end
    endtask

    task automatic test_normal_run;
        logic [2:0] exp_start [5];
        logic       exp_ksel [5];
        int         busy_cnt = 0;
        exp_start = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100};
        exp_ksel  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ready = 1'b1; tick(); ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 11; c++) begin
                if (busy === 1'b1) busy_cnt++;
                if (c == 0 || c == 5) begin
                    total++;
                    if (step !== 3'(s + 1)) begin
                        bad++; $display("FAIL run_step s=%0d c=%0d got=%0d exp=%0d", s, c, step, s + 1);
                    end
                    total++;
                    if ({l2_start, l1_start, l0_start} !== ((c == 0) ? exp_start[s] : 3'b000)) begin
                        bad++; $display("FAIL run_start s=%0d c=%0d got=%b", s, c,
                                        {l2_start, l1_start, l0_start});
                    end
                    total++;
                    if (ksel !== exp_ksel[s]) begin
                        bad++; $display("FAIL run_ksel s=%0d got=%b exp=%b", s, ksel, exp_ksel[s]);
                    end
                end
                if (c == 10) pulse_done(s);
                else tick();
            end
        end
        total++; if (busy_cnt != 55) begin bad++; $display("FAIL run_busy_cycles got=%0d exp=55", busy_cnt); end
        total++; if (step !== 3'd6) begin bad++; $display("FAIL run_fin got=%0d exp=6", step); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL run_fin_busy got=%b exp=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL run_err got=%b exp=0", err); end
        tick();
        total++; if (step !== 3'd0) begin bad++; $display("FAIL run_idle got=%0d exp=0", step); end
    endtask

    task automatic test_csel;
        int exp_csel [5][4];
        exp_csel = '{'{1, 1, 1, 1}, '{2, 2, 2, 2}, '{1, 3, 1, 3}, '{2, 4, 2, 4}, '{3, 5, 4, 5}};
        ready = 1'b1; tick(); ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < 4; k++) begin
                eng_wr = k[0];
                l2_src = k[1];
                #1;
                total++;
                if (csel !== 3'(exp_csel[s][k])) begin
                    bad++; $display("FAIL csel s=%0d wr=%b src=%b got=%b exp=%0d", s, eng_wr, l2_src,
                                    csel, exp_csel[s][k]);
                end
            end
            tick();
            pulse_done(s);
        end
        total++; if (step !== 3'd6) begin bad++; $display("FAIL csel_fin_step got=%0d exp=6", step); end
        total++; if (csel !== 3'd0) begin bad++; $display("FAIL csel_fin got=%b exp=000", csel); end
        tick();
        total++; if (csel !== 3'd0) begin bad++; $display("FAIL csel_idle got=%b exp=000", csel); end
        eng_wr = 1'b0; l2_src = 1'b0;
    endtask

    task automatic test_timeout;
        logic seen_l2 = 1'b0;
        ready = 1'b1; tick(); ready = 1'b0;
        tick(); pulse_done(0);
        tick(); pulse_done(1);
        for (int c = 0; c < 21; c++) begin
            seen_l2 |= l2_start;
            if (c == 20) begin
                total++;
                if (step !== 3'd3 || err !== 1'b0) begin
                    bad++; $display("FAIL to_before step=%0d err=%b exp step=3 err=0", step, err);
                end
            end
            tick();
        end
        total++; if (step !== 3'd6) begin bad++; $display("FAIL to_fin got=%0d exp=6", step); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy got=%b exp=0", busy); end
        for (int c = 0; c < 4; c++) begin
            seen_l2 |= l2_start;
            tick();
        end
        total++; if (step !== 3'd0) begin bad++; $display("FAIL to_idle got=%0d exp=0", step); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", err); end
        total++; if (seen_l2 !== 1'b0) begin bad++; $display("FAIL to_l2_start got=%b exp=0", seen_l2); end
        ready = 1'b1; tick(); ready = 1'b0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL to_err_clear got=%b exp=0", err); end
        reset = 1'b0; #1; reset = 1'b1; tick();
    endtask

    task automatic test_spurious_and_async_reset;
        logic [2:0] starts_seen = 3'b000;
        ready = 1'b1; tick(); ready = 1'b0;
        l0_done = 1'b1; l2_done = 1'b1;
        tick();
        l0_done = 1'b0; l2_done = 1'b0;
        total++; if (step !== 3'd1) begin bad++; $display("FAIL sp_coincident got=%0d exp=1", step); end
        l1_done = 1'b1; l2_done = 1'b1;
        tick();
        l1_done = 1'b0; l2_done = 1'b0;
        total++; if (step !== 3'd1) begin bad++; $display("FAIL sp_foreign got=%0d exp=1", step); end
        pulse_done(0);
        total++;
        if (step !== 3'd2 || l0_start !== 1'b1 || ksel !== 1'b1) begin
            bad++; $display("FAIL sp_advance step=%0d l0s=%b ksel=%b exp 2/1/1", step, l0_start, ksel);
        end
        tick(); pulse_done(1);
        tick(); pulse_done(2);
        tick();
        eng_wr = 1'b1;
        #1;
        total++;
        if (step !== 3'd4 || csel !== 3'b100) begin
            bad++; $display("FAIL ar_pre step=%0d csel=%b exp 4/100", step, csel);
        end
        #2; reset = 1'b0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", busy); end
        total++; if (csel !== 3'd0) begin bad++; $display("FAIL ar_csel got=%b exp=000", csel); end
        total++; if (step !== 3'd0) begin bad++; $display("FAIL ar_step got=%0d exp=0", step); end
        #2; reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            starts_seen |= {l2_start, l1_start, l0_start};
        end
        total++;
        if (starts_seen !== 3'b000 || step !== 3'd0) begin
            bad++; $display("FAIL ar_quiet starts=%b step=%0d exp 000/0", starts_seen, step);
        end
        eng_wr = 1'b0;
        ready = 1'b1; tick(); ready = 1'b0;
        total++;
        if (step !== 3'd1 || l0_start !== 1'b1) begin
            bad++; $display("FAIL ar_restart step=%0d l0s=%b exp 1/1", step, l0_start);
        end
        reset = 1'b0; #1; reset = 1'b1; tick();
    endtask

    task automatic test_done_at_timeout;
        ready = 1'b1; tick(); ready = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        total++;
        if (step !== 3'd1 || err !== 1'b0) begin
            bad++; $display("FAIL dt_before step=%0d err=%b exp 1/0", step, err);
        end
        pulse_done(0);
        total++; if (step !== 3'd2) begin bad++; $display("FAIL dt_step got=%0d exp=2", step); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL dt_err got=%b exp=0", err); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL dt_busy got=%b exp=1", busy); end
    endtask

    initial begin
        test_reset();
        test_normal_run();
        test_csel();
        test_timeout();
        test_spurious_and_async_reset();
        test_done_at_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
